// File: rtl/loop_scan_ctrl.sv
// Two-level row/column scan scheduler: start/done protocol, shadowed bounds,
// and a valid/ready index stream that stalls on backpressure.
module loop_scan_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] rows_max,
  input  logic [DW-1:0] cols_max,
  output logic          busy,
  output logic          done,
  output logic          idx_valid,
  input  logic          idx_ready,
  output logic [DW-1:0] row,
  output logic [DW-1:0] col,
  output logic          first,
  output logic          row_last,
  output logic          last
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] row_nx, col_nx;
  logic [DW-1:0] rmax_s, cmax_s, rmax_nx, cmax_nx;
  logic          fire;

  // Outputs decode registered state only, so an async reset drops them at once.
  assign busy      = (state == RUN);
  assign idx_valid = (state == RUN);
  assign done      = (state == DONE);
  assign fire      = idx_valid & idx_ready;
  assign first     = idx_valid && (row == '0) && (col == '0);
  assign row_last  = idx_valid && (col == cmax_s);
  assign last      = row_last && (row == rmax_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      rmax_s <= '0;
      cmax_s <= '0;
    end else begin
      state  <= state_nx;
      row    <= row_nx;
      col    <= col_nx;
      rmax_s <= rmax_nx;
      cmax_s <= cmax_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    rmax_nx  = rmax_s;
    cmax_nx  = cmax_s;
    case (state)
      IDLE: begin
        if (start) begin
          rmax_nx  = rows_max;
          cmax_nx  = cols_max;
          row_nx   = '0;
          col_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        // Abort wins over a coincident final beat: the scan ends without done.
        if (abort) begin
          row_nx   = '0;
          col_nx   = '0;
          state_nx = IDLE;
        end else if (fire) begin
          if (!row_last) begin
            col_nx = col + 1'b1;
          end else if (!last) begin
            col_nx = '0;
            row_nx = row + 1'b1;
          end else begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        row_nx   = '0;
        col_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        row_nx   = '0;
        col_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule
